// File: rtl/exu_issue_ctrl.sv
// Issue controller with a 32-entry register scoreboard: stalls decoded instructions on
// RAW/WAW hazards or exhausted write credits, and holds accepted ones in a one-entry issue register.
module exu_issue_ctrl #(
    parameter int MAX_INFLIGHT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dcd_valid,
    output logic        dcd_ready,
    input  logic [4:0]  dcd_lsrc1,
    input  logic [4:0]  dcd_lsrc2,
    input  logic [4:0]  dcd_ldst,
    input  logic        dcd_src1_en,
    input  logic        dcd_src2_en,
    input  logic        dcd_dst_en,
    output logic        iss_valid,
    input  logic        iss_ready,
    output logic [4:0]  iss_lsrc1,
    output logic [4:0]  iss_lsrc2,
    output logic [4:0]  iss_ldst,
    output logic        iss_dst_en,
    input  logic        wb0_valid,
    input  logic [4:0]  wb0_addr,
    input  logic        wb1_valid,
    input  logic [4:0]  wb1_addr,
    output logic [31:0] busy_vec,
    output logic [3:0]  inflight_cnt
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

    logic        iss_valid_q, iss_valid_d;
    logic [4:0]  iss_lsrc1_q, iss_lsrc1_d;
    logic [4:0]  iss_lsrc2_q, iss_lsrc2_d;
    logic [4:0]  iss_ldst_q, iss_ldst_d;
    logic        iss_dst_en_q, iss_dst_en_d;
    logic [31:0] busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;

    logic hazard_s, credit_stall_s, ready_s, accept_s, set_s, clr0_s, clr1_s;

    // Hazard and credit checks use registered scoreboard state only (no writeback bypass).
    always_comb begin
        hazard_s = (dcd_src1_en && (dcd_lsrc1 != 5'd0) && busy_q[dcd_lsrc1])
                || (dcd_src2_en && (dcd_lsrc2 != 5'd0) && busy_q[dcd_lsrc2])
                || (dcd_dst_en  && (dcd_ldst  != 5'd0) && busy_q[dcd_ldst]);
        credit_stall_s = dcd_dst_en && (dcd_ldst != 5'd0) && (cnt_q == MAX_CNT);
        ready_s  = (!iss_valid_q || iss_ready) && !hazard_s && !credit_stall_s;
        accept_s = dcd_valid && ready_s;
        set_s    = accept_s && dcd_dst_en && (dcd_ldst != 5'd0);
        clr0_s   = wb0_valid && (wb0_addr != 5'd0);
        clr1_s   = wb1_valid && (wb1_addr != 5'd0);
    end

    // Next-state for the issue register, scoreboard and in-flight counter.
    always_comb begin
        iss_valid_d  = iss_valid_q;
        iss_lsrc1_d  = iss_lsrc1_q;
        iss_lsrc2_d  = iss_lsrc2_q;
        iss_ldst_d   = iss_ldst_q;
        iss_dst_en_d = iss_dst_en_q;
        busy_d       = busy_q;

        if (accept_s) begin
            iss_valid_d  = 1'b1;
            iss_lsrc1_d  = dcd_lsrc1;
            iss_lsrc2_d  = dcd_lsrc2;
            iss_ldst_d   = dcd_ldst;
            iss_dst_en_d = dcd_dst_en;
        end else if (iss_valid_q && iss_ready) begin
            iss_valid_d = 1'b0;
        end else begin
            iss_valid_d = iss_valid_q;
        end

        if (clr0_s) begin
            busy_d[wb0_addr] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (clr1_s) begin
            busy_d[wb1_addr] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        // Set is applied after the clears so it wins on a same-register collision.
        if (set_s) begin
            busy_d[dcd_ldst] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;

        cnt_d = cnt_q + {3'd0, set_s} - {3'd0, clr0_s} - {3'd0, clr1_s};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q  <= 1'b0;
            iss_lsrc1_q  <= 5'd0;
            iss_lsrc2_q  <= 5'd0;
            iss_ldst_q   <= 5'd0;
            iss_dst_en_q <= 1'b0;
            busy_q       <= 32'd0;
            cnt_q        <= 4'd0;
        end else begin
            iss_valid_q  <= iss_valid_d;
            iss_lsrc1_q  <= iss_lsrc1_d;
            iss_lsrc2_q  <= iss_lsrc2_d;
            iss_ldst_q   <= iss_ldst_d;
            iss_dst_en_q <= iss_dst_en_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
        end
    end

    assign dcd_ready    = ready_s;
    assign iss_valid    = iss_valid_q;
    assign iss_lsrc1    = iss_lsrc1_q;
    assign iss_lsrc2    = iss_lsrc2_q;
    assign iss_ldst     = iss_ldst_q;
    assign iss_dst_en   = iss_dst_en_q;
    assign busy_vec     = busy_q;
    assign inflight_cnt = cnt_q;

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Directed bench for exu_issue_ctrl: a set-of-pending-registers model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_exu_issue_ctrl;

    localparam int MAXI = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dcd_valid = 1'b0;
    logic        dcd_ready;
    logic [4:0]  dcd_lsrc1 = 5'd0, dcd_lsrc2 = 5'd0, dcd_ldst = 5'd0;
    logic        dcd_src1_en = 1'b0, dcd_src2_en = 1'b0, dcd_dst_en = 1'b0;
    logic        iss_valid;
    logic        iss_ready = 1'b1;
    logic [4:0]  iss_lsrc1, iss_lsrc2, iss_ldst;
    logic        iss_dst_en;
    logic        wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic [4:0]  wb0_addr = 5'd0, wb1_addr = 5'd0;
    logic [31:0] busy_vec;
    logic [3:0]  inflight_cnt;

    int n_chk = 0;
    int n_fail = 0;

    exu_issue_ctrl #(.MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .rst(rst),
        .dcd_valid(dcd_valid), .dcd_ready(dcd_ready),
        .dcd_lsrc1(dcd_lsrc1), .dcd_lsrc2(dcd_lsrc2), .dcd_ldst(dcd_ldst),
        .dcd_src1_en(dcd_src1_en), .dcd_src2_en(dcd_src2_en), .dcd_dst_en(dcd_dst_en),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_lsrc1(iss_lsrc1), .iss_lsrc2(iss_lsrc2), .iss_ldst(iss_ldst),
        .iss_dst_en(iss_dst_en),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr),
        .busy_vec(busy_vec), .inflight_cnt(inflight_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which registers have an outstanding write, how many, and what sits in the issue slot.
    bit         pend[32];
    int         outstanding;
    bit         m_valid;
    logic [4:0] m_s1, m_s2, m_d;
    bit         m_den;
    bit         chk_en = 1'b0;

    function automatic bit m_ready();
        bit haz, credit;
        haz = (dcd_src1_en && dcd_lsrc1 != 5'd0 && pend[dcd_lsrc1])
           || (dcd_src2_en && dcd_lsrc2 != 5'd0 && pend[dcd_lsrc2])
           || (dcd_dst_en  && dcd_ldst  != 5'd0 && pend[dcd_ldst]);
        credit = dcd_dst_en && dcd_ldst != 5'd0 && outstanding == MAXI;
        return (!m_valid || iss_ready) && !haz && !credit;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = pend[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) pend[i] = 1'b0;
            outstanding = 0;
            m_valid = 1'b0;
            m_s1 = 5'd0; m_s2 = 5'd0; m_d = 5'd0; m_den = 1'b0;
        end else begin
            bit acc;
            acc = dcd_valid && m_ready();
            // Upstream protocol: writebacks only to registers that are pending, never both ports to one.
            if (wb0_valid && wb0_addr != 5'd0) chk("proto_wb0_pending", 32'(pend[wb0_addr]), 32'd1);
            if (wb1_valid && wb1_addr != 5'd0) chk("proto_wb1_pending", 32'(pend[wb1_addr]), 32'd1);
            if (wb0_valid && wb1_valid && wb0_addr != 5'd0)
                chk("proto_wb_same_addr", 32'(wb0_addr == wb1_addr), 32'd0);
            if (wb0_valid && wb0_addr != 5'd0) begin pend[wb0_addr] = 1'b0; outstanding--; end
            if (wb1_valid && wb1_addr != 5'd0) begin pend[wb1_addr] = 1'b0; outstanding--; end
            if (acc) begin
                m_valid = 1'b1;
                m_s1 = dcd_lsrc1; m_s2 = dcd_lsrc2; m_d = dcd_ldst; m_den = dcd_dst_en;
                if (dcd_dst_en && dcd_ldst != 5'd0) begin pend[dcd_ldst] = 1'b1; outstanding++; end
            end else if (iss_ready) begin
                m_valid = 1'b0;
            end
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dcd_ready", 32'(dcd_ready), 32'(m_ready()));
            chk("iss_valid", 32'(iss_valid), 32'(m_valid));
            chk("iss_lsrc1", 32'(iss_lsrc1), 32'(m_s1));
            chk("iss_lsrc2", 32'(iss_lsrc2), 32'(m_s2));
            chk("iss_ldst", 32'(iss_ldst), 32'(m_d));
            chk("iss_dst_en", 32'(iss_dst_en), 32'(m_den));
            chk("busy_vec", busy_vec, m_busy());
            chk("inflight_cnt", 32'(inflight_cnt), 32'(outstanding));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [4:0] s1, input bit e1,
                         input logic [4:0] s2, input bit e2, input logic [4:0] d, input bit ed);
        dcd_valid = v;
        dcd_lsrc1 = s1; dcd_src1_en = e1;
        dcd_lsrc2 = s2; dcd_src2_en = e2;
        dcd_ldst  = d;  dcd_dst_en  = ed;
    endtask

    task automatic wb(input bit v0, input logic [4:0] a0, input bit v1, input logic [4:0] a1);
        wb0_valid = v0; wb0_addr = a0;
        wb1_valid = v1; wb1_addr = a1;
    endtask

    initial begin
        // Reset
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_cnt", 32'(inflight_cnt), 32'd0);
        chk("rst_valid", 32'(iss_valid), 32'd0);
        chk("rst_ready", 32'(dcd_ready), 32'd1);

        // Single accept of dst 5
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("acc5_busy", busy_vec, 32'h20);
        chk("acc5_cnt", 32'(inflight_cnt), 32'd1);
        chk("acc5_valid", 32'(iss_valid), 32'd1);
        chk("acc5_ldst", 32'(iss_ldst), 32'd5);

        // RAW on r5 until writeback clears it
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("raw_stall", 32'(dcd_ready), 32'd0);
        tick(); tick();
        wb(1'b1, 5'd5, 1'b0, 5'd0);
        tick();
        wb(1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("raw_release", 32'(dcd_ready), 32'd1);
        chk("raw_busy5", 32'(busy_vec[5]), 32'd0);
        tick();

        // x0 never causes a hazard nor consumes credit
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("x0_ready", 32'(dcd_ready), 32'd1);
            tick();
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("x0_busy", busy_vec, 32'h0);
        chk("x0_cnt", 32'(inflight_cnt), 32'd0);

        // Credit exhaustion at MAX_INFLIGHT
        for (int d = 1; d <= 8; d++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(d), 1'b1);
            tick();
        end
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        @(negedge clk);
        chk("credit_cnt8", 32'(inflight_cnt), 32'd8);
        chk("credit_stall", 32'(dcd_ready), 32'd0);
        tick();
        wb(1'b0, 5'd0, 1'b1, 5'd3);
        tick();
        wb(1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("credit_cnt7", 32'(inflight_cnt), 32'd7);
        chk("credit_release", 32'(dcd_ready), 32'd1);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("credit_refill", 32'(inflight_cnt), 32'd8);
        chk("credit_ldst9", 32'(iss_ldst), 32'd9);
        wb(1'b1, 5'd1, 1'b1, 5'd2); tick();
        wb(1'b1, 5'd4, 1'b1, 5'd5); tick();
        wb(1'b1, 5'd6, 1'b1, 5'd7); tick();
        wb(1'b1, 5'd8, 1'b1, 5'd9); tick();
        wb(1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("drain_cnt", 32'(inflight_cnt), 32'd0);

        // Backpressure holds the issue register
        iss_ready = 1'b0;
        drive(1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 5'd10, 1'b1);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", 32'(dcd_ready), 32'd0);
            chk("bp_ldst", 32'(iss_ldst), 32'd10);
            chk("bp_lsrc1", 32'(iss_lsrc1), 32'd11);
            chk("bp_lsrc2", 32'(iss_lsrc2), 32'd12);
            tick();
        end
        iss_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(dcd_ready), 32'd1);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("bp_nobubble_valid", 32'(iss_valid), 32'd1);
        chk("bp_nobubble_ldst", 32'(iss_ldst), 32'd13);
        wb(1'b1, 5'd10, 1'b1, 5'd13); tick();
        wb(1'b0, 5'd0, 1'b0, 5'd0);

        // Dual writeback in one cycle
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1); tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("dual_busy_pre", busy_vec, 32'h90);
        wb(1'b1, 5'd4, 1'b1, 5'd7); tick();
        wb(1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("dual_busy", busy_vec, 32'h0);
        chk("dual_cnt", 32'(inflight_cnt), 32'd0);

        // Mid-operation reset with a writeback in the reset cycle
        for (int d = 1; d <= 3; d++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(d), 1'b1);
            tick();
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        wb(1'b1, 5'd1, 1'b0, 5'd0);
        tick();
        rst = 1'b0;
        wb(1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("mrst_valid", 32'(iss_valid), 32'd0);
        chk("mrst_busy", busy_vec, 32'h0);
        chk("mrst_cnt", 32'(inflight_cnt), 32'd0);
        chk("mrst_ldst", 32'(iss_ldst), 32'd0);
        chk("mrst_dst_en", 32'(iss_dst_en), 32'd0);
        chk("mrst_ready", 32'(dcd_ready), 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exu_issue_ctrl.md
# exu_issue_ctrl

Issue controller and register scoreboard between the decoder and the register file in the execute unit. It accepts decoded instructions (logical sources and destination) over a valid/ready handshake. It stalls any instruction whose sources or destination are still pending writeback, and holds accepted instructions in a one-entry issue register that drives the regfile read addresses. Writeback ports clear busy bits, and an in-flight counter enforces a maximum number of outstanding writes.

## Interface
- MAX_INFLIGHT, default 8: maximum instructions issued but not yet written back (1..15).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- dcd_valid  in  1  decoded instruction present.
- dcd_ready  out  1  instruction accepted this cycle when high together with dcd_valid.
- dcd_lsrc1, dcd_lsrc2, dcd_ldst  in  5 each  logical register numbers.
- dcd_src1_en, dcd_src2_en, dcd_dst_en  in  1 each  field is used by the instruction.
- iss_valid  out  1  issue register holds an instruction.
- iss_ready  in  1  downstream consumes the issue register this cycle.
- iss_lsrc1, iss_lsrc2, iss_ldst  out  5 each  registered fields; lsrc1/lsrc2 drive regfile readAddrVec_0/1.
- iss_dst_en  out  1  registered dst_en.
- wb0_valid, wb1_valid  in  1 each  writeback on regfile write port 0/1.
- wb0_addr, wb1_addr  in  5 each  writeback destination.
- busy_vec  out  32  scoreboard state, bit i = register i pending.
- inflight_cnt  out  4  current outstanding-write count.

## Operation
- Hazard = (src1_en & busy[lsrc1]) | (src2_en & busy[lsrc2]) | (dst_en & busy[ldst]). Covers RAW and WAW.
- Register x0 is never busy. Any field equal to 0 never causes a hazard, and dst 0 neither sets busy nor counts as in-flight.
- Busy is checked against registered busy_vec only. There is no same-cycle bypass of writeback clears.
- Credit stall: dcd_dst_en & ldst!=0 & inflight_cnt == MAX_INFLIGHT.
- dcd_ready = (~iss_valid | iss_ready) & ~hazard & ~credit_stall. It is combinational from registered state and dcd_* only, and does not depend on dcd_valid.
- Accept (dcd_valid & dcd_ready):
  - Load the issue register and set iss_valid.
  - If dst_en and ldst!=0, set busy[ldst] and increment the in-flight count.
- Consume without accept (iss_valid & iss_ready & no accept): clear iss_valid. Issue register fields hold their last value.
- Writeback: each valid wbN with addr!=0 clears busy[addr] and decrements the in-flight count by 1.
- If wb0 and wb1 target the same nonzero register in one cycle, the bit is cleared once and the count is decremented by 2. This case is a protocol error upstream and is flagged by a bench assertion.
- Writeback to a non-busy register still decrements the count. This is a protocol error, also asserted by the bench.
- Simultaneous set and clear of the same register in one cycle (accept dst == wb addr): set wins and busy remains 1. This cannot arise legally, since the accept requires busy=0 and a writeback implies busy=1.
- Count next = cnt + set − (number of clears). The arithmetic is 4-bit and never wraps under legal traffic.

## Timing
- Reset (rst high at an edge), all synchronous:
  - iss_valid=0, busy_vec=0, inflight_cnt=0, iss_* fields=0, iss_dst_en=0.
  - dcd_ready evaluates high after reset, provided iss_ready is don't-care and iss_valid=0.
- Reset mid-operation discards the issue register and all pending state. Writebacks arriving in the reset cycle are ignored.
- Latency: accept at edge N makes iss_valid visible in cycle N+1. Back-to-back independent instructions sustain 1/cycle while iss_ready stays high.
- Writeback at edge N clears busy, so a dependent instruction presented in cycle N+1 is accepted at edge N+1. Minimum producer-writeback to dependent-accept latency is 1 cycle.
- Held dcd_* inputs while dcd_valid & ~dcd_ready are re-evaluated every cycle. There is no internal decode buffering.
- iss_* outputs are stable while iss_valid & ~iss_ready.

## Test plan
- Reset, then accept ldst=5 (dst_en, no sources): busy_vec=0x20 and inflight_cnt=1 next cycle; iss_valid=1 and iss_ldst=5.
- RAW: accept ldst=5, then present lsrc1=5 → dcd_ready=0. Pulse wb0 addr=5 at cycle K → dcd_ready=1 in cycle K+1, and busy[5]=0.
- x0: accept ldst=0 with lsrc1=0, src1_en=1, repeated 20 cycles → always accepted, busy_vec=0, inflight_cnt=0.
- Credit: MAX_INFLIGHT=8. Accept dst 1..8 with no writebacks → inflight_cnt=8 and dst 9 is stalled. A single wb1 addr=3 → dst 9 accepted the next cycle and inflight_cnt=8.
- Backpressure: iss_ready=0 with iss_valid=1 → dcd_ready=0 and iss_* fields are unchanged for 5 cycles. Raise iss_ready with a new accept in the same cycle → the next instruction appears with no bubble.
- Dual writeback plus reset: busy regs 4 and 7, wb0=4 and wb1=7 in the same cycle → busy_vec=0 and cnt=0. Then fill 3 entries and assert rst for 1 cycle → all outputs return to reset values on the next cycle.
